// File: rtl/uart_rx_fsm_pkg.sv
// uart_rx_fsm_pkg: baud divisors for a 12 MHz clock and receiver state encoding.
package uart_rx_fsm_pkg;
  localparam int B300 = 40000;
  localparam int B1200 = 10000;
  localparam int B2400 = 5000;
  localparam int B9600 = 1250;
  localparam int B19200 = 625;
  localparam int B57600 = 208;
  localparam int B115200 = 104;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
endpackage

// File: rtl/uart_rx_fsm_baudgen_rx.sv
// baudgen_rx: bit-period down-counter with half-period preload; tick marks each mid-bit sample point.
module baudgen_rx #(
  parameter int BAUD = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic load_half,
  output logic tick
);
  localparam int W = $clog2(BAUD);
  logic [W-1:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (load_half) cnt <= W'(BAUD / 2 - 1);
    else if (tick) cnt <= W'(BAUD - 1);
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 receiver sampling a synchronised rx line at mid-bit.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int BAUD = B115200,
  parameter int SYNC = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);
  state_t state, state_n;
  logic [SYNC-1:0] sync;
  logic rx_s, tick, rcv_n, ferr_n;
  logic [7:0] sh, sh_n, data_n;
  logic [2:0] bitc, bitc_n;
  assign rx_s = sync[SYNC-1];
  assign busy = state != IDLE;
  baudgen_rx #(.BAUD(BAUD)) u_baud (
    .clk(clk),
    .rstn(rstn),
    .en(state == START || state == DATA || state == STOP),
    .load_half(state == IDLE && !rx_s),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync <= '1;
      state <= IDLE;
      sh <= '0;
      bitc <= '0;
      data <= '0;
      rcv <= 1'b0;
      ferr <= 1'b0;
    end else begin
      sync <= {sync[SYNC-2:0], rx};
      state <= state_n;
      sh <= sh_n;
      bitc <= bitc_n;
      data <= data_n;
      rcv <= rcv_n;
      ferr <= ferr_n;
    end
  always_comb begin
    state_n = state;
    sh_n = sh;
    bitc_n = bitc;
    data_n = data;
    rcv_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: state_n = rx_s ? IDLE : START;
      START:
        if (tick) begin
          state_n = rx_s ? IDLE : DATA;
          bitc_n = '0;
        end
      DATA:
        if (tick) begin
          sh_n = {rx_s, sh[7:1]};
          bitc_n = bitc + 3'd1;
          state_n = bitc == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (tick) begin
          state_n = rx_s ? IDLE : WAIT_HI;
          data_n = rx_s ? sh : data;
          rcv_n = rx_s;
          ferr_n = !rx_s;
        end
      WAIT_HI: state_n = rx_s ? IDLE : WAIT_HI;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames into a BAUD=8 receiver plus a BAUD=104 loopback instance.
module tb_uart_rx_fsm;
  localparam int BD = 8;
  localparam int LB = 104;
  logic clk = 1'b0, rstn = 1'b0, rx = 1'b1, rx_lb = 1'b1;
  logic [7:0] data, lb_data;
  logic rcv, ferr, busy, lb_rcv, lb_ferr, lb_busy;
  int total = 0, bad = 0, cyc = 0;
  int rcv_cnt = 0, ferr_cnt = 0, both_cnt = 0, lb_cnt = 0;
  logic [7:0] rx_q[$];
  int lb_t[$];
  int r0, f0, p1, p2;

  uart_rx_fsm #(.BAUD(BD), .SYNC(2)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .data(data), .rcv(rcv), .ferr(ferr), .busy(busy)
  );
  uart_rx_fsm #(.BAUD(LB), .SYNC(2)) u_lb (
    .clk(clk), .rstn(rstn), .rx(rx_lb), .data(lb_data), .rcv(lb_rcv), .ferr(lb_ferr), .busy(lb_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rcv) begin
      rcv_cnt++;
      rx_q.push_back(data);
    end
    if (ferr) ferr_cnt++;
    if (rcv && ferr) both_cnt++;
    if (lb_rcv) begin
      lb_cnt++;
      lb_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int nbits, input int baud, input logic lb);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (lb) rx_lb = f[i];
      else rx = f[i];
      repeat (baud) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_rcv", rcv, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    idle(4);

    r0 = rcv_cnt; f0 = ferr_cnt;
    send(8'h41, 1'b1, 10, BD, 1'b0);
    idle(2 * BD);
    chk("f41_rcv", rcv_cnt - r0, 1);
    chk("f41_data", data, 8'h41);
    chk("f41_ferr", ferr_cnt - f0, 0);

    r0 = rcv_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * BD);
    chk("glitch_rcv", rcv_cnt - r0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_data", data, 8'h41);
    chk("glitch_busy", busy, 1'b0);

    r0 = rcv_cnt; f0 = ferr_cnt;
    send(8'h55, 1'b0, 10, BD, 1'b0);
    idle(40);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_rcv", rcv_cnt - r0, 0);
    chk("brk_data", data, 8'h41);
    chk("brk_busy_low", busy, 1'b1);
    rx = 1'b1;
    idle(2 * BD);
    chk("brk_busy_rel", busy, 1'b0);
    send(8'h3C, 1'b1, 10, BD, 1'b0);
    idle(2 * BD);
    chk("f3c_rcv", rcv_cnt - r0, 1);
    chk("f3c_data", data, 8'h3C);
    chk("f3c_ferr", ferr_cnt - f0, 1);

    r0 = rcv_cnt; f0 = ferr_cnt;
    rx_q.delete();
    send(8'h00, 1'b1, 10, BD, 1'b0);
    send(8'hFF, 1'b1, 10, BD, 1'b0);
    idle(2 * BD);
    chk("b2b_cnt", rcv_cnt - r0, 2);
    chk("b2b_first", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h00);
    chk("b2b_second", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'hFF);
    chk("b2b_data", data, 8'hFF);

    send(8'hA5, 1'b1, 5, BD, 1'b0);
    rx = 1'b1;
    idle(BD / 2);
    chk("mid_busy_pre", busy, 1'b1);
    #3 rstn = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_data", data, 8'h00);
    chk("mid_rcv", rcv, 1'b0);
    chk("mid_ferr", ferr, 1'b0);
    idle(2);
    rstn = 1'b1;
    idle(2 * BD);
    r0 = rcv_cnt; f0 = ferr_cnt;
    send(8'hA5, 1'b1, 10, BD, 1'b0);
    idle(2 * BD);
    chk("fa5_rcv", rcv_cnt - r0, 1);
    chk("fa5_data", data, 8'hA5);
    chk("fa5_ferr", ferr_cnt - f0, 0);

    lb_t.delete();
    r0 = lb_cnt;
    for (int k = 0; k < 3; k++) send(8'h41, 1'b1, 10, LB, 1'b1);
    idle(LB);
    chk("lb_cnt", lb_cnt - r0, 3);
    chk("lb_data", lb_data, 8'h41);
    chk("lb_ferr", lb_ferr, 1'b0);
    p1 = lb_t.size() >= 2 ? lb_t[1] - lb_t[0] : 0;
    p2 = lb_t.size() >= 3 ? lb_t[2] - lb_t[1] : 0;
    chk("lb_period1", p1, 10 * LB);
    chk("lb_period2", p2, 10 * LB);

    chk("never_both", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
